alu_dispatch: RTL

//   Issue side of the minigpu ALU interface: drives wrapper_alu's alu_en/alu_func/a/b and collects out.

---
 rtl/alu_dispatch_pkg.sv | 33 +++
 rtl/alu_lat_counter.sv | 30 +++
 rtl/alu_dispatch.sv | 114 +++++++++++
 3 files changed

// File: rtl/alu_dispatch_pkg.sv
// Shared definitions for the minigpu ALU issue path: opcode values, dispatcher
// state encoding and the latency-counter width helper.
package alu_dispatch_pkg;

  localparam int unsigned ALU_DATA_W_DEF    = 16;
  localparam int unsigned ALU_FUNC_W_DEF    = 4;
  localparam int unsigned ALU_TAG_W_DEF     = 4;
  localparam int unsigned ALU_NUM_FUNCS_DEF = 8;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } disp_state_e;

  // A zero-latency ALU still needs a one-bit counter to hold the constant 0.
  function automatic int unsigned lat_cnt_width(input int unsigned lat);
    int unsigned w;
    w = 1;
    while ((1 << w) < (lat + 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// Load/decrement counter timing the fixed ALU latency; zero flags the capture cycle.
module alu_lat_counter
  import alu_dispatch_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int unsigned CNT_W = lat_cnt_width(ALU_LAT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(ALU_LAT);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/alu_dispatch.sv
// Issue side of the minigpu ALU: takes one op at a time, drives the shared ALU
// for its fixed latency and returns the tagged result on a valid/ready port.
module alu_dispatch
  import alu_dispatch_pkg::*;
#(
  parameter int unsigned DATA_W    = ALU_DATA_W_DEF,
  parameter int unsigned FUNC_W    = ALU_FUNC_W_DEF,
  parameter int unsigned TAG_W     = ALU_TAG_W_DEF,
  parameter int unsigned ALU_LAT   = 1,
  parameter int unsigned NUM_FUNCS = ALU_NUM_FUNCS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [FUNC_W-1:0] req_func,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              alu_en,
  output logic [FUNC_W-1:0] alu_func,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err,
  output logic              busy
);

  disp_state_e      state;
  logic [TAG_W-1:0] tag_q;
  logic             fire;
  logic             legal;
  logic             cnt_zero;
  logic             cnt_load;
  logic             cnt_dec;

  assign req_ready = (state == IDLE) | ((state == RESP) & rsp_ready);
  assign fire      = req_valid & req_ready;
  assign legal     = ({1'b0, req_func} < (FUNC_W + 1)'(NUM_FUNCS));
  assign busy      = (state != IDLE);

  assign cnt_load  = fire & legal;
  assign cnt_dec   = (state == EXEC) & ~cnt_zero;

  alu_lat_counter #(
    .ALU_LAT (ALU_LAT)
  ) u_lat_counter (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tag_q     <= '0;
      alu_en    <= 1'b0;
      alu_func  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        EXEC: begin
          if (cnt_zero) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_out;
            rsp_tag   <= tag_q;
            rsp_err   <= 1'b0;
            alu_en    <= 1'b0;
            state     <= RESP;
          end
        end
        IDLE, RESP: begin
          // IDLE and RESP share the fire path so a consumed response can be
          // replaced by the next op in the same cycle without a bubble.
          if ((state == RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
          if (fire) begin
            if (legal) begin
              alu_en   <= 1'b1;
              alu_func <= req_func;
              alu_a    <= req_a;
              alu_b    <= req_b;
              tag_q    <= req_tag;
              state    <= EXEC;
            end else begin
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_tag   <= req_tag;
              rsp_err   <= 1'b1;
              state     <= RESP;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
